// File: rtl/alu_op_sequencer.sv
// Purpose: one-at-a-time command/response front end for the Kolache ALU slices.
// Latency: logic, arithmetic and shift-by-0 take 1 cycle. A shift by k takes k+1 cycles, one bit per cycle.
// Backpressure: the result is held in DONE until rsp_ready. cmd_ready stays low from acceptance until the cycle after the response handshake.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SHW-1:0]   cnt;
    logic             shift_right;

    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

    // Opcodes 110/111 are the shifts; bit 0 selects the right shift.
    assign is_shift   = cmd_op[2] & cmd_op[1];
    assign amt        = cmd_b[SHW-1:0];

    assign cmd_ready  = (state == IDLE) && !rst;
    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign rsp_zero   = (rsp_result == '0);
    assign rsp_neg    = rsp_result[WIDTH-1];

    // Single-cycle ALU on the incoming command. SUB reuses the adder as a + ~b + 1.
    // Shifts pass cmd_a through: that is the final value for amount 0 and the start value otherwise.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        b_eff     = cmd_op[0] ? ~cmd_b : cmd_b;
        add_ext   = {1'b0, cmd_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cmd_op[0]};
        case (cmd_op)
            3'b000: alu_res = cmd_a | cmd_b;
            3'b001: alu_res = cmd_a & cmd_b;
            3'b010: alu_res = cmd_a ^ cmd_b;
            3'b011: alu_res = ~(cmd_a | cmd_b);
            3'b100, 3'b101: begin
                alu_res   = add_ext[WIDTH-1:0];
                alu_carry = add_ext[WIDTH];
                // Comparing against b_eff covers both cases: equal signs for ADD, different signs for SUB.
                alu_ovf   = (cmd_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != cmd_a[WIDTH-1]);
            end
            default: alu_res = cmd_a;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A nonzero shift goes to SHIFT; every other command goes straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (is_shift && (amt != '0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result, flag and shift-count registers. During SHIFT, rsp_result is the work register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_ovf     <= 1'b0;
            cnt         <= '0;
            shift_right <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_result  <= alu_res;
                        rsp_carry   <= alu_carry;
                        rsp_ovf     <= alu_ovf;
                        cnt         <= is_shift ? amt : '0;
                        shift_right <= cmd_op[0];
                    end
                end
                SHIFT: begin
                    if (shift_right) begin
                        rsp_carry  <= rsp_result[0];
                        rsp_result <= {1'b0, rsp_result[WIDTH-1:1]};
                    end else begin
                        rsp_carry  <= rsp_result[WIDTH-1];
                        rsp_result <= {rsp_result[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
